regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 63 ++++++
 tb/tb_regfile_sb.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared CPU constants for the register file and its scoreboard.
// The optional write-to-read bypass is selected with REGFILE_BYPASS_EN.
package regfile_sb_pkg;
  localparam int CPU_XLEN   = 32;
  localparam int CPU_REG_AW = 5;
  localparam int REG_NUM    = 32;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue increments, write-back decrements, flush clears.
// REGFILE_BYPASS_EN hides busy when the only outstanding write is being written back this cycle.
module regfile_scoreboard import regfile_sb_pkg::*; #(
  parameter int REG_AW = CPU_REG_AW,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_en,
  input  logic [REG_AW-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [REG_AW-1:0] rs1_raddr,
  input  logic [REG_AW-1:0] rs2_raddr,
  output logic              rs1_busy,
  output logic              rs2_busy
);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  logic [CNT_W-1:0] cnt [REG_NUM];
  logic             inc;
  logic             dec;

  // Issue handshake: an issue is accepted only on a cycle where iss_en and
  // iss_ready are both high; iss_en while iss_ready is low is dropped.
  assign iss_ready = (cnt[iss_addr] != CNT_MAX);
  assign inc       = iss_en && iss_ready && (iss_addr != ZERO_ADDR);
  assign dec       = wr_en && (wr_addr != ZERO_ADDR) && (cnt[wr_addr] != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (inc && iss_addr == REG_AW'(i) && !(dec && wr_addr == REG_AW'(i)))
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec && wr_addr == REG_AW'(i) && !(inc && iss_addr == REG_AW'(i)))
          cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    rs1_busy = (cnt[rs1_raddr] != '0);
    rs2_busy = (cnt[rs2_raddr] != '0);
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == rs1_raddr && rs1_raddr != ZERO_ADDR && cnt[rs1_raddr] == CNT_ONE)
      rs1_busy = 1'b0;
    if (wr_en && wr_addr == rs2_raddr && rs2_raddr != ZERO_ADDR && cnt[rs2_raddr] == CNT_ONE)
      rs2_busy = 1'b0;
`endif
  end
endmodule

// File: rtl/regfile_sb.sv
// Two-read one-write register file (x0 hardwired to zero) with a pending-write scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module regfile_sb import regfile_sb_pkg::*; #(
  parameter int XLEN   = CPU_XLEN,
  parameter int REG_AW = CPU_REG_AW,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_AW-1:0] rs1_raddr,
  input  logic [REG_AW-1:0] rs2_raddr,
  output logic [XLEN-1:0]   rs1_rdata,
  output logic [XLEN-1:0]   rs2_rdata,
  input  logic              iss_en,
  input  logic [REG_AW-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              flush,
  output logic              rs1_busy,
  output logic              rs2_busy
);
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  logic [XLEN-1:0] regs [REG_NUM];

  // Flush only clears the scoreboard; write-back data still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != ZERO_ADDR) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_rdata = (rs1_raddr == ZERO_ADDR) ? '0 : regs[rs1_raddr];
    rs2_rdata = (rs2_raddr == ZERO_ADDR) ? '0 : regs[rs2_raddr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == rs1_raddr && rs1_raddr != ZERO_ADDR) rs1_rdata = wr_data;
    if (wr_en && wr_addr == rs2_raddr && rs2_raddr != ZERO_ADDR) rs2_rdata = wr_data;
`endif
  end

  regfile_scoreboard #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rs1_raddr (rs1_raddr),
    .rs2_raddr (rs2_raddr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random stimulus for regfile_sb against an array-based model of registers and pending counts.
// Honours REGFILE_BYPASS_EN so the same bench covers both builds.
module tb_regfile_sb;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        rst, wr_en, iss_en, flush;
  logic [4:0]  wr_addr, rs1_raddr, rs2_raddr, iss_addr;
  logic [31:0] wr_data, rs1_rdata, rs2_rdata;
  logic        iss_ready, rs1_busy, rs2_busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] regs_m [32];
  int          cnt_m  [32];

  regfile_sb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return regs_m[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a && a != 0 && cnt_m[a] == 1) return 1'b0;
`endif
    return cnt_m[a] != 0;
  endfunction

  // Drive one cycle's inputs just after the falling edge and check every output against the model.
  task automatic apply(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic ie,
                       input logic [4:0] ia, input logic fl);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rs1_raddr = a1; rs2_raddr = a2; iss_en = ie; iss_addr = ia; flush = fl;
    #1;
    chk("rs1_rdata", rs1_rdata, exp_rd(a1));
    chk("rs2_rdata", rs2_rdata, exp_rd(a2));
    chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(a1)});
    chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(a2)});
    chk("iss_ready", {31'b0, iss_ready}, {31'b0, cnt_m[ia] < CMAX});
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    bit do_inc, do_dec;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin regs_m[i] = 32'h0; cnt_m[i] = 0; end
    end else begin
      if (wr_en && wr_addr != 0) regs_m[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) cnt_m[i] = 0;
      end else begin
        do_inc = iss_en && cnt_m[iss_addr] < CMAX && iss_addr != 0;
        do_dec = wr_en && wr_addr != 0 && cnt_m[wr_addr] > 0;
        if (!(do_inc && do_dec && iss_addr == wr_addr)) begin
          if (do_inc) cnt_m[iss_addr] = cnt_m[iss_addr] + 1;
          if (do_dec) cnt_m[wr_addr] = cnt_m[wr_addr] - 1;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rs1_raddr = '0; rs2_raddr = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    tick();

    // Reset state
    apply(0, 0, 0, 0, 5, 7, 0, 3, 0);
    chk("reset_rs1_rdata", rs1_rdata, 32'h0);
    chk("reset_busy", {30'b0, rs1_busy, rs2_busy}, 32'h0);
    chk("reset_iss_ready", {31'b0, iss_ready}, 32'h1);

    // Write x5 then read it back; x0 writes are discarded
    apply(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 5, 0, 0, 0, 0);
    chk("x5_read", rs1_rdata, 32'hDEADBEEF); tick();
    apply(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_read", rs1_rdata, 32'h0); tick();

    // Same-cycle write and read of x7
    apply(0, 1, 7, 32'hA5A5A5A5, 0, 7, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
    chk("x7_same_cycle", rs2_rdata, 32'hA5A5A5A5);
`else
    chk("x7_same_cycle", rs2_rdata, 32'h0);
`endif
    tick();

    // Saturate x3, then drain it
    for (int k = 0; k < 3; k++) begin apply(0, 0, 0, 0, 3, 0, 1, 3, 0); tick(); end
    apply(0, 0, 0, 0, 3, 0, 1, 3, 0);
    chk("x3_sat_ready", {31'b0, iss_ready}, 32'h0);
    chk("x3_sat_busy", {31'b0, rs1_busy}, 32'h1);
    tick();
    for (int k = 0; k < 3; k++) begin apply(0, 1, 3, 32'h300 + k, 3, 0, 0, 3, 0); tick(); end
    apply(0, 0, 0, 0, 3, 0, 0, 3, 0);
    chk("x3_drained_busy", {31'b0, rs1_busy}, 32'h0);
    chk("x3_drained_ready", {31'b0, iss_ready}, 32'h1);
    tick();

    // Coincident issue and write-back on x9 with one pending write
    apply(0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
    apply(0, 1, 9, 32'h99, 9, 0, 1, 9, 0); tick();
    apply(0, 0, 0, 0, 9, 0, 0, 9, 0);
    chk("x9_still_busy", {31'b0, rs1_busy}, 32'h1); tick();
    apply(0, 1, 9, 32'h999, 0, 0, 0, 0, 0); tick();

    // Flush with pending x4/x6, simultaneous issue x8 and write x12
    apply(0, 0, 0, 0, 0, 0, 1, 4, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1, 6, 0); tick();
    apply(0, 1, 12, 32'hCAFEF00D, 4, 6, 1, 8, 1); tick();
    apply(0, 0, 0, 0, 4, 6, 0, 0, 0);
    chk("flush_busy46", {30'b0, rs1_busy, rs2_busy}, 32'h0);
    apply(0, 0, 0, 0, 8, 12, 0, 0, 0);
    chk("flush_busy8", {31'b0, rs1_busy}, 32'h0);
    chk("flush_wdata", rs2_rdata, 32'hCAFEF00D);
    tick();

    // Reset during a write with pending counters
    apply(0, 0, 0, 0, 0, 0, 1, 10, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1, 11, 0); tick();
    apply(1, 1, 10, 32'hFFFFFFFF, 10, 11, 1, 10, 1); tick();
    apply(0, 0, 0, 0, 10, 11, 0, 0, 0);
    chk("rst_x10", rs1_rdata, 32'h0);
    chk("rst_busy", {30'b0, rs1_busy, rs2_busy}, 32'h0);
    tick();

    // Random traffic on a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(63) == 0, $urandom_range(1), 5'($urandom_range(7)), $urandom,
            5'($urandom_range(7)), 5'($urandom_range(7)), $urandom_range(1),
            5'($urandom_range(7)), $urandom_range(31) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
